instruction_fetch_unit: RTL and testbench

Front end of the pipeline: owns the PC/nPC pair, fetches 32-bit words from instruction memory over a req/ack handshake, and drives the fetched instruction and its address into the IF/ID stage register. Honours the IF/ID load enable (`le`) from the hazard unit as a stall. Applies control-transfer redirects with one delay slot: the redirect target replaces nPC, not PC.

---
 rtl/if_pkg.sv | 18 +
 rtl/pc_npc_reg.sv | 64 ++++++
 rtl/instruction_fetch_unit.sv | 96 +++++++++
 tb/tb_instruction_fetch_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch front end.
package if_pkg;

    localparam int unsigned PC_W      = 9;
    localparam int unsigned PC_INC    = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } if_state_e;

    // Control-transfer targets are byte addresses; fetches are word aligned.
    function automatic logic [PC_W-1:0] alignWord(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/pc_npc_reg.sv
// PC/nPC pair with a latch that remembers a redirect seen while IF/ID is stalled,
// so the target lands in nPC (one delay slot) on the next advance.
module pc_npc_reg
    import if_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            advance_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] target_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] npc_o
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] npc_q, npc_d;
    logic [PC_W-1:0] pendTgt_q, pendTgt_d;
    logic            pend_q, pend_d;
    logic [PC_W-1:0] tgtAligned;

    assign tgtAligned = alignWord(target_i);

    // A redirect arriving with the advance beats any older pending target.
    always_comb begin
        pc_d      = pc_q;
        npc_d     = npc_q;
        pend_d    = pend_q;
        pendTgt_d = pendTgt_q;
        if (advance_i) begin
            pc_d   = npc_q;
            pend_d = 1'b0;
            if (redirect_i) begin
                npc_d = tgtAligned;
            end else if (pend_q) begin
                npc_d = pendTgt_q;
            end else begin
                npc_d = npc_q + PC_W'(PC_INC);
            end
        end else if (redirect_i) begin
            pend_d    = 1'b1;
            pendTgt_d = tgtAligned;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            pc_q      <= RESET_PC;
            npc_q     <= RESET_PC + PC_W'(PC_INC);
            pend_q    <= 1'b0;
            pendTgt_q <= '0;
        end else begin
            pc_q      <= pc_d;
            npc_q     <= npc_d;
            pend_q    <= pend_d;
            pendTgt_q <= pendTgt_d;
        end
    end

    assign pc_o  = pc_q;
    assign npc_o = npc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Pipeline front end: fetches one word per PC over a req/ack handshake and holds it
// in registered outputs until the IF/ID stage accepts it.
module instruction_fetch_unit
    import if_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            le,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_target,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [31:0]     instruction_out,
    output logic [PC_W-1:0] pc_out,
    output logic            valid_out
);

    if_state_e       state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pcOut_q, pcOut_d;
    logic            valid_q, valid_d;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] npc;
    logic            advance;

    assign advance = (state_q == HOLD) && le;

    pc_npc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_npc (
        .clk_i      (clk),
        .reset_ni   (reset),
        .advance_i  (advance),
        .redirect_i (redirect),
        .target_i   (redirect_target),
        .pc_o       (pc),
        .npc_o      (npc)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pcOut_d = pcOut_q;
        valid_d = valid_q;
        unique case (state_q)
            FETCH: begin
                if (imem_req && imem_ack) begin
                    instr_d = imem_data;
                    pcOut_d = pc;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (le) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FETCH;
            instr_q <= NOP_INSTR;
            pcOut_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pcOut_q <= pcOut_d;
            valid_q <= valid_d;
        end
    end

    // The request is masked while reset is asserted so no fetch escapes a reset cycle.
    assign imem_req        = (state_q == FETCH) && reset;
    assign imem_addr       = pc;
    assign instruction_out = instr_q;
    assign pc_out          = pcOut_q;
    assign valid_out       = valid_q;

    logic unusedNpc;
    assign unusedNpc = ^npc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a scoreboard of expected fetch addresses
// is filled as stimulus is driven and drained each time a new instruction appears.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        le;
    logic        redirect;
    logic [8:0]  redirect_target;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instruction_out;
    logic [8:0]  pc_out;
    logic        valid_out;

    int          vecCount  = 0;
    int          failCount = 0;
    int          waitLeft  = 0;
    logic        prevValid = 1'b0;
    logic [8:0]  expQ[$];

    instruction_fetch_unit #(
        .RESET_PC (9'd0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .le              (le),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_data       (imem_data),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .valid_out       (valid_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare a newly presented instruction against the oldest expected fetch.
    task automatic scoreboardPop();
        logic [8:0] expPc;
        if (expQ.size() == 0) begin
            checkOutput("sb_unexpected_valid", 32'(pc_out), 32'h1FF);
        end else begin
            expPc = expQ.pop_front();
            checkOutput("sb_pc_out", 32'(pc_out), 32'(expPc));
            checkOutput("sb_instr", instruction_out, 32'hAAAA0000 + 32'(expPc));
        end
    endtask

    // One clock: drive inputs, let memory answer the current request, sample after the edge.
    task automatic applyStimulus(input logic leV, input logic redirV, input logic [8:0] tgtV,
                                 input logic rstV, input logic forceAck);
        reset           = rstV;
        le              = leV;
        redirect        = redirV;
        redirect_target = tgtV;
        #1;
        imem_ack  = 1'b0;
        imem_data = 32'h0;
        if (forceAck) begin
            imem_ack  = 1'b1;
            imem_data = 32'hDEADBEEF;
        end else if (imem_req) begin
            if (waitLeft > 0) begin
                waitLeft--;
            end else begin
                imem_ack  = 1'b1;
                imem_data = 32'hAAAA0000 + 32'(imem_addr);
            end
        end
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        redirect = 1'b0;
        if (valid_out && !prevValid) scoreboardPop();
        prevValid = valid_out;
    endtask

    // Advance out of HOLD (optionally with a redirect) then take a zero-wait fetch.
    task automatic advanceAndFetch(input logic redirV, input logic [8:0] tgtV, input logic [8:0] expAddr);
        expQ.push_back(expAddr);
        applyStimulus(1'b1, redirV, tgtV, 1'b1, 1'b0);
        checkOutput("bubble_valid", 32'(valid_out), 32'd0);
        checkOutput("bubble_instr", instruction_out, 32'h0);
        applyStimulus(1'b1, 1'b0, 9'd0, 1'b1, 1'b0);
        checkOutput("fetched_valid", 32'(valid_out), 32'd1);
    endtask

    initial begin
        reset = 1'b0; le = 1'b0; redirect = 1'b0; redirect_target = '0;
        imem_ack = 1'b0; imem_data = '0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 9'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 9'd0, 1'b0, 1'b0);
        checkOutput("rst_valid", 32'(valid_out), 32'd0);
        checkOutput("rst_instr", instruction_out, 32'h0);
        checkOutput("rst_pc_out", 32'(pc_out), 32'd0);
        checkOutput("rst_req_low", 32'(imem_req), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("first_req", 32'(imem_req), 32'd1);
        checkOutput("first_addr", 32'(imem_addr), 32'd0);

        // Zero-wait sequential fetch, le held high
        expQ.push_back(9'd0);
        applyStimulus(1'b1, 1'b0, 9'd0, 1'b1, 1'b0);
        checkOutput("fetched_valid", 32'(valid_out), 32'd1);
        advanceAndFetch(1'b0, 9'd0, 9'd4);

        // Three wait cycles at PC=8
        expQ.push_back(9'd8);
        applyStimulus(1'b1, 1'b0, 9'd0, 1'b1, 1'b0);
        waitLeft = 3;
        for (int i = 0; i < 4; i++) begin
            checkOutput("wait_req", 32'(imem_req), 32'd1);
            checkOutput("wait_addr", 32'(imem_addr), 32'd8);
            applyStimulus(1'b1, 1'b0, 9'd0, 1'b1, 1'b0);
            checkOutput("wait_valid", 32'(valid_out), (i == 3) ? 32'd1 : 32'd0);
        end
        advanceAndFetch(1'b0, 9'd0, 9'd12);
        advanceAndFetch(1'b0, 9'd0, 9'h10);

        // Stall in HOLD with a redirect mid-stall: delay slot then target
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, (i == 1), 9'h40, 1'b1, 1'b0);
            checkOutput("stall_pc_out", 32'(pc_out), 32'h10);
            checkOutput("stall_instr", instruction_out, 32'hAAAA0010);
            checkOutput("stall_valid", 32'(valid_out), 32'd1);
            checkOutput("stall_req", 32'(imem_req), 32'd0);
        end
        advanceAndFetch(1'b0, 9'd0, 9'h14);
        advanceAndFetch(1'b0, 9'd0, 9'h40);

        // Redirect coinciding with advance, unaligned target
        advanceAndFetch(1'b1, 9'h1C, 9'h44);
        advanceAndFetch(1'b0, 9'd0, 9'h1C);
        advanceAndFetch(1'b0, 9'd0, 9'h20);
        advanceAndFetch(1'b1, 9'h103, 9'h24);
        advanceAndFetch(1'b0, 9'd0, 9'h100);
        advanceAndFetch(1'b0, 9'd0, 9'h104);
        advanceAndFetch(1'b0, 9'd0, 9'h108);

        // Two redirects during a stall: the last one wins
        applyStimulus(1'b0, 1'b1, 9'h80, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 9'h90, 1'b1, 1'b0);
        advanceAndFetch(1'b0, 9'd0, 9'h10C);
        advanceAndFetch(1'b0, 9'd0, 9'h90);

        // Address wrap at the top of the instruction space
        advanceAndFetch(1'b1, 9'h1F8, 9'h94);
        advanceAndFetch(1'b0, 9'd0, 9'h1F8);
        advanceAndFetch(1'b0, 9'd0, 9'h1FC);
        advanceAndFetch(1'b0, 9'd0, 9'h000);

        // Reset during FETCH with a simultaneous ack
        applyStimulus(1'b1, 1'b0, 9'd0, 1'b1, 1'b0);
        checkOutput("pre_rst_valid", 32'(valid_out), 32'd0);
        applyStimulus(1'b0, 1'b0, 9'd0, 1'b0, 1'b1);
        checkOutput("rst_ack_valid", 32'(valid_out), 32'd0);
        checkOutput("rst_ack_instr", instruction_out, 32'h0);
        checkOutput("rst_ack_pc_out", 32'(pc_out), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rerelease_req", 32'(imem_req), 32'd1);
        checkOutput("rerelease_addr", 32'(imem_addr), 32'd0);
        expQ.push_back(9'd0);
        applyStimulus(1'b1, 1'b0, 9'd0, 1'b1, 1'b0);
        checkOutput("fetched_valid", 32'(valid_out), 32'd1);

        checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
